serial_pattern_scan_ctrl: RTL and testbench

Sequencing controller for the serial 1001/010 Mealy pattern detector. It accepts parallel words over a valid/ready handshake and shifts each one, a bit per cycle, into an embedded detector core. For each word it records which bit positions completed a pattern and how many matches occurred, then holds the result for a downstream consumer under valid/ready. It sits between a parallel producer and the detector, so the detector never needs a serial-bit driver of its own.

---
 rtl/serial_scan_pkg.sv | 24 ++
 rtl/seq_det_core.sv | 59 +++++
 rtl/serial_pattern_scan_ctrl.sv | 128 ++++++++++++
 tb/tb_serial_pattern_scan_ctrl.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/serial_scan_pkg.sv
// -----------------------------------------------------------------------------
// serial_scan_pkg
// Shared types for the serial pattern scan controller and its detector core:
//   - ctrl_state_t : controller FSM states (IDLE / SHIFT / REPORT)
//   - det_state_t  : 3-bit binary encodings S0..S5 of the 1001/010 detector
// -----------------------------------------------------------------------------
package serial_scan_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        REPORT = 2'd2
    } ctrl_state_t;

    typedef enum logic [2:0] {
        S0 = 3'd0,
        S1 = 3'd1,
        S2 = 3'd2,
        S3 = 3'd3,
        S4 = 3'd4,
        S5 = 3'd5
    } det_state_t;

endpackage

// File: rtl/seq_det_core.sv
// -----------------------------------------------------------------------------
// seq_det_core
// Mealy detector for the overlapping patterns 1001 and 010 on a serial bit x.
// Ports:
//   clk     in  clock
//   reset_n in  asynchronous active-low reset (state -> S0)
//   clr     in  synchronous clear to S0 (takes priority over en)
//   en      in  1: consume x this cycle; 0: hold state, y forced to 0
//   x       in  serial input bit
//   y       out 1 when the current bit completes a pattern (combinational)
// -----------------------------------------------------------------------------
module seq_det_core
    import serial_scan_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic en,
    input  logic x,
    output logic y
);

    det_state_t state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // S1 = "0", S2 = "01", S3 = "10", S4 = "1", S5 = "100".
    // S2 on 0 ends 010, S5 on 1 ends 1001; no bit can end both.
    always_comb begin
        state_d = state_q;
        y       = 1'b0;
        if (clr) begin
            state_d = S0;
        end else if (en) begin
            case (state_q)
                S0: state_d = x ? S4 : S1;
                S1: state_d = x ? S2 : S1;
                S2: begin
                    state_d = x ? S4 : S3;
                    y       = ~x;
                end
                S3: state_d = x ? S2 : S5;
                S4: state_d = x ? S4 : S3;
                S5: begin
                    state_d = x ? S2 : S1;
                    y       = x;
                end
                default: state_d = S0;
            endcase
        end
    end

endmodule

// File: rtl/serial_pattern_scan_ctrl.sv
// -----------------------------------------------------------------------------
// serial_pattern_scan_ctrl
// Accepts parallel words over valid/ready, shifts them one bit per cycle into
// seq_det_core, and reports the per-bit hit mask and match count.
// Parameters:
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  1: in_data[WIDTH-1] shifted first; 0: in_data[0] first
//   CNT_W      width of out_count
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   in_valid/in_ready       word handshake (in_ready high only in IDLE)
//   in_data                 word to scan
//   in_keep_history         1: keep detector state, 0: clear it on accept
//   out_valid/out_ready     result handshake (out_valid high only in REPORT)
//   out_count               number of matches in the word
//   out_hit_mask            bit i set iff the i-th shifted bit completed a match
//   busy                    high in SHIFT or REPORT
// -----------------------------------------------------------------------------
module serial_pattern_scan_ctrl
    import serial_scan_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_keep_history,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [WIDTH-1:0] out_hit_mask,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    ctrl_state_t      state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [WIDTH-1:0] mask_q,  mask_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [IDX_W-1:0] idx_q,   idx_d;

    logic core_clr;
    logic core_en;
    logic core_x;
    logic core_y;

    seq_det_core u_core (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (core_clr),
        .en      (core_en),
        .x       (core_x),
        .y       (core_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            mask_q  <= '0;
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            mask_q  <= mask_d;
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        mask_d   = mask_q;
        count_d  = count_q;
        idx_d    = idx_q;
        core_clr = 1'b0;
        core_en  = 1'b0;
        core_x   = MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0];

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shreg_d  = in_data;
                    idx_d    = '0;
                    count_d  = '0;
                    mask_d   = '0;
                    // Clear lands on the accept edge, so the first shifted bit
                    // already sees the detector in S0.
                    core_clr = ~in_keep_history;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                core_en        = 1'b1;
                mask_d[idx_q]  = core_y;
                count_d        = count_q + CNT_W'(core_y);
                idx_d          = idx_q + 1'b1;
                shreg_d        = MSB_FIRST ? (shreg_q << 1) : (shreg_q >> 1);
                if (idx_q == LAST_IDX) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Count and mask registers double as the held result; they are only
    // modified in SHIFT, so they stay stable throughout REPORT.
    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == REPORT);
    assign busy         = (state_q != IDLE);
    assign out_count    = count_q;
    assign out_hit_mask = mask_q;

endmodule

// File: tb/tb_serial_pattern_scan_ctrl.sv
module tb_serial_pattern_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;

    // DUT a: MSB first
    logic       a_in_valid, a_in_ready, a_in_keep, a_out_valid, a_out_ready, a_busy;
    logic [7:0] a_in_data, a_mask;
    logic [3:0] a_count;

    // DUT b: LSB first
    logic       b_in_valid, b_in_ready, b_in_keep, b_out_valid, b_out_ready, b_busy;
    logic [7:0] b_in_data, b_mask;
    logic [3:0] b_count;

    int n_checks = 0;
    int n_fail   = 0;

    serial_pattern_scan_ctrl #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (a_in_valid),
        .in_ready        (a_in_ready),
        .in_data         (a_in_data),
        .in_keep_history (a_in_keep),
        .out_valid       (a_out_valid),
        .out_ready       (a_out_ready),
        .out_count       (a_count),
        .out_hit_mask    (a_mask),
        .busy            (a_busy)
    );

    serial_pattern_scan_ctrl #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
        .clk             (clk),
        .reset_n         (reset_n),
        .in_valid        (b_in_valid),
        .in_ready        (b_in_ready),
        .in_data         (b_in_data),
        .in_keep_history (b_in_keep),
        .out_valid       (b_out_valid),
        .out_ready       (b_out_ready),
        .out_count       (b_count),
        .out_hit_mask    (b_mask),
        .busy            (b_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One complete transaction: accept, measure latency, check result, drain.
    task automatic run_word(input bit sel, input logic [7:0] data, input bit keep,
                            input int exp_cnt, input logic [7:0] exp_mask, input string tag);
        int waitc;
        @(negedge clk);
        check({tag, "_in_ready_idle"}, sel ? b_in_ready : a_in_ready, 1);
        if (sel) begin
            b_in_valid = 1'b1; b_in_data = data; b_in_keep = keep; b_out_ready = 1'b0;
        end else begin
            a_in_valid = 1'b1; a_in_data = data; a_in_keep = keep; a_out_ready = 1'b0;
        end
        @(posedge clk);   // accept edge T0
        @(negedge clk);
        a_in_valid = 1'b0;
        b_in_valid = 1'b0;
        check({tag, "_busy_shift"}, sel ? b_busy : a_busy, 1);
        waitc = 0;
        while (!(sel ? b_out_valid : a_out_valid) && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        // out_valid appears after edge T0+WIDTH
        check({tag, "_latency_edges"}, waitc, 8);
        check({tag, "_count"}, sel ? b_count : a_count, exp_cnt);
        check({tag, "_mask"},  sel ? b_mask  : a_mask,  exp_mask);
        check({tag, "_in_ready_report"}, sel ? b_in_ready : a_in_ready, 0);
        if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        b_out_ready = 1'b0;
        check({tag, "_out_valid_drained"}, sel ? b_out_valid : a_out_valid, 0);
        check({tag, "_busy_drained"}, sel ? b_busy : a_busy, 0);
    endtask

    initial begin
        reset_n     = 1'b0;
        a_in_valid  = 1'b0; a_in_data = '0; a_in_keep = 1'b0; a_out_ready = 1'b0;
        b_in_valid  = 1'b0; b_in_data = '0; b_in_keep = 1'b0; b_out_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        check("rst_in_ready",  a_in_ready,  1);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_count",     a_count,     0);
        check("rst_mask",      a_mask,      0);
        check("rst_busy",      a_busy,      0);
        check("rst_b_in_ready", b_in_ready, 1);
        reset_n = 1'b1;

        // Basic words
        run_word(1'b0, 8'b1001_0010, 1'b0, 4, 8'b1101_1000, "w1001_0010");
        run_word(1'b0, 8'b0101_0101, 1'b0, 3, 8'b0101_0100, "w0101_0101");
        run_word(1'b0, 8'hFF,        1'b0, 0, 8'h00,        "wFF");
        run_word(1'b0, 8'h00,        1'b0, 0, 8'h00,        "w00");

        // History across words (first word leaves the detector in S5)
        run_word(1'b0, 8'b0000_0100, 1'b0, 1, 8'b0100_0000, "hist_first");
        run_word(1'b0, 8'b1000_0000, 1'b1, 2, 8'b0000_0011, "hist_keep");
        run_word(1'b0, 8'b0000_0100, 1'b0, 1, 8'b0100_0000, "hist_first2");
        run_word(1'b0, 8'b1000_0000, 1'b0, 0, 8'b0000_0000, "hist_clear");

        // Backpressure: hold REPORT with in_valid pulsing
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 8'b0101_0101; a_in_keep = 1'b0; a_out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a_in_valid = 1'b0;
        begin
            int waitc;
            waitc = 0;
            while (!a_out_valid && waitc < 20) begin
                @(negedge clk);
                waitc++;
            end
            check("bp_latency_edges", waitc, 8);
        end
        for (int i = 0; i < 5; i++) begin
            a_in_valid = i[0] ? 1'b0 : 1'b1;
            a_in_data  = 8'b1001_0010;
            @(negedge clk);
            check("bp_out_valid", a_out_valid, 1);
            check("bp_count",     a_count,     3);
            check("bp_mask",      a_mask,      8'b0101_0100);
            check("bp_in_ready",  a_in_ready,  0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_out_ready = 1'b0;
        check("bp_released_in_ready", a_in_ready, 1);
        @(negedge clk);
        check("bp_no_accept_busy", a_busy, 0);

        // Asynchronous reset in the 4th SHIFT cycle of 1001_0010
        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 8'b1001_0010; a_in_keep = 1'b0;
        @(posedge clk);
        @(negedge clk);       // 1st SHIFT cycle
        a_in_valid = 1'b0;
        repeat (3) @(negedge clk);  // 4th SHIFT cycle
        check("ar_busy_before", a_busy, 1);
        #1 reset_n = 1'b0;
        #1;
        check("ar_in_ready",  a_in_ready,  1);
        check("ar_out_valid", a_out_valid, 0);
        check("ar_busy",      a_busy,      0);
        check("ar_count",     a_count,     0);
        check("ar_mask",      a_mask,      0);
        @(negedge clk);
        reset_n = 1'b1;
        // keep=1: result is only right if the detector restarted from S0
        run_word(1'b0, 8'b0101_0101, 1'b1, 3, 8'b0101_0100, "ar_next");

        // LSB-first instance sees the same bit stream as the first word
        run_word(1'b1, 8'b0100_1001, 1'b0, 4, 8'b1101_1000, "lsb_first");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
